// File: rtl/gs_acq_pkg.sv
// Shared types and constants for the GS multi-channel raw-signal capture path.
package gs_acq_pkg;

  localparam logic [3:0] OP_START = 4'h1;
  localparam logic [3:0] OP_ABORT = 4'h2;
  localparam logic [3:0] HDR_MARK = 4'hA;
  localparam logic [3:0] TRL_MARK = 4'h5;

  typedef struct packed {
    logic [3:0]  op;
    logic [7:0]  mask;
    logic [19:0] cnt;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HDR,
    ST_ADDR,
    ST_PUSH,
    ST_NEXT,
    ST_GAP,
    ST_TRL
  } state_e;

  function automatic logic [15:0] hdr_word(input logic [7:0] mask);
    return {HDR_MARK, 4'h0, mask};
  endfunction

  function automatic logic [15:0] trl_word(input logic aborted);
    return {TRL_MARK, 3'b000, aborted, 8'h00};
  endfunction

endpackage

// File: rtl/gs_chan_sched.sv
// Finds the next enabled channel at or above 'from', falling back to the lowest
// enabled channel with next_wrap set when none remains.
module gs_chan_sched #(
  parameter int unsigned NCH = 4
) (
  input  logic [NCH-1:0]                               mask,
  input  logic [$clog2(NCH+1)-1:0]                     from,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]     next_idx,
  output logic                                         next_wrap,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]     low_idx
);

  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

  // Scan downward so the last hit is the lowest qualifying index.
  always_comb begin
    next_idx  = '0;
    next_wrap = 1'b1;
    low_idx   = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (mask[i]) begin
        low_idx = CW'(i);
        if (i >= int'(from)) begin
          next_idx  = CW'(i);
          next_wrap = 1'b0;
        end
      end
    end
    if (next_wrap) next_idx = low_idx;
  end

endmodule

// File: rtl/gs_multichan_capture.sv
// Command-driven multi-channel capture: sweeps a channel mask over the register
// file and frames the samples with header/trailer words into the output FIFO.
module gs_multichan_capture
  import gs_acq_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter int unsigned DW       = 16,
  parameter int unsigned AW       = 8,
  parameter int unsigned CNT_W    = 20,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned READ_LAT = 1
) (
  input  logic             iClk,
  input  logic             iReset_n,
  input  logic [31:0]      iCmdData,
  input  logic             iCmdEmpty,
  output logic             oCmdRd,
  output logic [AW-1:0]    oAddr,
  output logic [7:0]       oSignSelec,
  input  logic [DW-1:0]    iReg,
  input  logic [DIV_W-1:0] iPeriod,
  output logic [DW-1:0]    oData,
  output logic             oWr,
  input  logic             iFull,
  output logic             oEof,
  output logic             oBusy
);

  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned FW = $clog2(NCH + 1);
  localparam int unsigned LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  state_e             state_q, state_d;
  logic [7:0]         mask_q, mask_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   s_q, s_d;
  logic [CW-1:0]      c_q, c_d;
  logic               abort_q, abort_d;
  logic [LW-1:0]      lat_q, lat_d;
  logic [DIV_W-1:0]   gap_q, gap_d;
  logic [DW-1:0]      smp_q, smp_d;
  logic [DW-1:0]      data_q, data_d;
  logic               wr_q, wr_d;
  logic               rd_q, rd_d;
  logic               eof_q, eof_d;
  logic               busy_q, busy_d;

  cmd_t               cmd_w;
  logic [CW-1:0]      next_idx;
  logic               next_wrap;
  logic [CW-1:0]      low_idx;

  assign cmd_w = cmd_t'(iCmdData);

  gs_chan_sched #(
    .NCH (NCH)
  ) u_sched (
    .mask      (mask_q[NCH-1:0]),
    .from      (FW'(c_q) + FW'(1)),
    .next_idx  (next_idx),
    .next_wrap (next_wrap),
    .low_idx   (low_idx)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    n_d     = n_q;
    s_d     = s_q;
    c_d     = c_q;
    abort_d = abort_q;
    lat_d   = lat_q;
    gap_d   = gap_q;
    smp_d   = smp_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    eof_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!iCmdEmpty) begin
          rd_d    = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        mask_d  = cmd_w.mask;
        n_d     = cmd_w.cnt[CNT_W-1:0];
        abort_d = 1'b0;
        if (cmd_w.op == OP_START && (|cmd_w.mask[NCH-1:0])) state_d = ST_HDR;
        else                                                state_d = ST_IDLE;
      end
      ST_HDR: begin
        if (!iFull) begin
          wr_d   = 1'b1;
          data_d = DW'(hdr_word(mask_q));
          if (n_q == '0) begin
            state_d = ST_TRL;
          end else begin
            s_d     = '0;
            c_d     = low_idx;
            lat_d   = '0;
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (lat_q == LW'(READ_LAT - 1)) begin
          smp_d   = iReg;
          state_d = ST_PUSH;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      ST_PUSH: begin
        if (!iFull) begin
          wr_d    = 1'b1;
          data_d  = smp_q;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        lat_d = '0;
        if (!next_wrap) begin
          c_d     = next_idx;
          state_d = ST_ADDR;
        end else if (s_q == n_q - CNT_W'(1)) begin
          state_d = ST_TRL;
        end else begin
          s_d = s_q + CNT_W'(1);
          c_d = next_idx;
          if (iPeriod == '0) begin
            state_d = ST_ADDR;
          end else begin
            gap_d   = iPeriod;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        // Only an ABORT is consumed here; any other command waits for IDLE.
        if (!iCmdEmpty && cmd_w.op == OP_ABORT) begin
          rd_d    = 1'b1;
          abort_d = 1'b1;
          state_d = ST_TRL;
        end else if (gap_q <= DIV_W'(1)) begin
          state_d = ST_ADDR;
        end else begin
          gap_d = gap_q - DIV_W'(1);
        end
      end
      ST_TRL: begin
        if (!iFull) begin
          wr_d    = 1'b1;
          eof_d   = 1'b1;
          data_d  = DW'(trl_word(abort_q));
          abort_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE) && (state_d != ST_FETCH);
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      n_q     <= '0;
      s_q     <= '0;
      c_q     <= '0;
      abort_q <= 1'b0;
      lat_q   <= '0;
      gap_q   <= '0;
      smp_q   <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      n_q     <= n_d;
      s_q     <= s_d;
      c_q     <= c_d;
      abort_q <= abort_d;
      lat_q   <= lat_d;
      gap_q   <= gap_d;
      smp_q   <= smp_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      eof_q   <= eof_d;
      busy_q  <= busy_d;
    end
  end

  // The read port follows the sample/channel registers directly.
  assign oAddr      = s_q[AW-1:0];
  assign oSignSelec = 8'(c_q);
  assign oData      = data_q;
  assign oWr        = wr_q;
  assign oCmdRd     = rd_q;
  assign oEof       = eof_q;
  assign oBusy      = busy_q;

endmodule

// File: tb/tb_gs_multichan_capture.sv
// Scoreboard bench for gs_multichan_capture: command FIFO model, register file
// echoing {select, address}, expected frames queued as commands are issued.
module tb_gs_multichan_capture;

  localparam int unsigned NCH      = 4;
  localparam int unsigned DW       = 16;
  localparam int unsigned AW       = 8;
  localparam int unsigned CNT_W    = 20;
  localparam int unsigned DIV_W    = 16;
  localparam int unsigned READ_LAT = 1;

  logic             iClk = 1'b0;
  logic             iReset_n;
  logic [31:0]      iCmdData = '0;
  logic             iCmdEmpty = 1'b1;
  logic             oCmdRd;
  logic [AW-1:0]    oAddr;
  logic [7:0]       oSignSelec;
  logic [DW-1:0]    iReg;
  logic [DIV_W-1:0] iPeriod;
  logic [DW-1:0]    oData;
  logic             oWr;
  logic             iFull;
  logic             oEof;
  logic             oBusy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int words = 0;
  int rd_cnt = 0;
  int eof_cnt = 0;
  int busy_cnt = 0;
  int rd_cyc = 0;
  int fall_cyc = 0;
  logic rd_pend = 1'b0;

  logic [16:0] exp_q[$];
  logic [31:0] cmd_fifo[$];
  int          wr_t[$];

  gs_multichan_capture #(
    .NCH(NCH), .DW(DW), .AW(AW), .CNT_W(CNT_W), .DIV_W(DIV_W), .READ_LAT(READ_LAT)
  ) dut (
    .iClk(iClk), .iReset_n(iReset_n), .iCmdData(iCmdData), .iCmdEmpty(iCmdEmpty),
    .oCmdRd(oCmdRd), .oAddr(oAddr), .oSignSelec(oSignSelec), .iReg(iReg),
    .iPeriod(iPeriod), .oData(oData), .oWr(oWr), .iFull(iFull), .oEof(oEof),
    .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  assign iReg = {oSignSelec, oAddr};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected frame: header, samples in (sample, ascending channel) order, trailer.
  task automatic push_frame(input logic [7:0] mask, input int n, input int abort_groups);
    int ng;
    ng = (abort_groups >= 0) ? abort_groups : n;
    exp_q.push_back({1'b0, 4'hA, 4'h0, mask});
    for (int s = 0; s < ng; s++)
      for (int c = 0; c < int'(NCH); c++)
        if (mask[c]) exp_q.push_back({1'b0, 8'(c), 8'(s)});
    exp_q.push_back({1'b1, 4'h5, 3'b000, (abort_groups >= 0), 8'h00});
  endtask

  task automatic wait_eof(input string tag, input int budget);
    int e0;
    int i;
    e0 = eof_cnt;
    i = 0;
    while (eof_cnt == e0 && i < budget) begin
      @(posedge iClk);
      i++;
    end
    check({tag, "_done"}, 32'(eof_cnt != e0), 32'd1);
    @(negedge iClk);
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_words(input string tag, input int target);
    for (int i = 0; i < 200 && words < target; i++) @(posedge iClk);
    check({tag, "_wait"}, 32'(words >= target), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmdrd"}, 32'(oCmdRd), 32'd0);
    check({tag, "_wr"},    32'(oWr), 32'd0);
    check({tag, "_eof"},   32'(oEof), 32'd0);
    check({tag, "_busy"},  32'(oBusy), 32'd0);
    check({tag, "_data"},  32'(oData), 32'd0);
    check({tag, "_addr"},  32'(oAddr), 32'd0);
    check({tag, "_sel"},   32'(oSignSelec), 32'd0);
  endtask

  // Command FIFO: pop on a read strobe seen in the previous cycle, FWFT output.
  always @(posedge iClk) begin
    logic prev_empty;
    cyc = cyc + 1;
    #1;
    if (rd_pend && cmd_fifo.size() > 0) void'(cmd_fifo.pop_front());
    prev_empty = iCmdEmpty;
    iCmdEmpty  = (cmd_fifo.size() == 0);
    iCmdData   = iCmdEmpty ? 32'h0 : cmd_fifo[0];
    if (prev_empty && !iCmdEmpty) fall_cyc = cyc;
  end

  // Output monitor and scoreboard.
  always @(negedge iClk) begin
    logic [16:0] e;
    rd_pend = oCmdRd;
    if (oCmdRd) begin
      rd_cnt++;
      rd_cyc = cyc;
    end
    if (oBusy) busy_cnt++;
    if (oEof) begin
      eof_cnt++;
      check("eof_with_wr", 32'(oWr), 32'd1);
    end
    if (oWr) begin
      words++;
      wr_t.push_back(cyc);
      check("wr_while_full", 32'(iFull), 32'd0);
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("data", 32'(oData), 32'(e[15:0]));
        check("eof", 32'(oEof), 32'(e[16]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len1;
    int rd0;
    int w0;
    int b0;
    len1 = 0;
    iReset_n = 1'b0;
    iFull    = 1'b0;
    iPeriod  = '0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    check_idle_outputs("reset");
    @(posedge iClk);
    #1 iReset_n = 1'b1;
    repeat (2) @(posedge iClk);

    // Two channels, two samples, back-to-back.
    wr_t.delete();
    rd0 = rd_cnt;
    push_frame(8'h03, 2, -1);
    cmd_fifo.push_back(32'h1030_0002);
    wait_eof("t1", 200);
    check("t1_rd_cnt", 32'(rd_cnt - rd0), 32'd1);
    check("t1_cmd_lat", 32'(rd_cyc - fall_cyc), 32'd1);
    check("t1_words", 32'(wr_t.size()), 32'd6);
    if (wr_t.size() == 6) begin
      check("t1_space1", 32'(wr_t[2] - wr_t[1]), 32'd3);
      check("t1_space2", 32'(wr_t[3] - wr_t[2]), 32'd3);
      check("t1_space3", 32'(wr_t[4] - wr_t[3]), 32'd3);
      len1 = wr_t[5] - wr_t[0];
    end

    // Same frame with five full cycles while the second sample is pending.
    wr_t.delete();
    w0 = words;
    push_frame(8'h03, 2, -1);
    cmd_fifo.push_back(32'h1030_0002);
    wait_words("t2", w0 + 2);
    @(posedge iClk);
    #1 iFull = 1'b1;
    repeat (5) @(posedge iClk);
    #1 iFull = 1'b0;
    wait_eof("t2", 200);
    check("t2_words", 32'(wr_t.size()), 32'd6);
    if (wr_t.size() == 6) check("t2_len", 32'(wr_t[5] - wr_t[0]), 32'(len1 + 5));

    // Abort queued behind a paced capture.
    iPeriod = 16'd10;
    rd0 = rd_cnt;
    push_frame(8'h05, 4, 1);
    cmd_fifo.push_back(32'h1050_0004);
    cmd_fifo.push_back(32'h2000_0000);
    wait_eof("t3", 400);
    check("t3_rd_cnt", 32'(rd_cnt - rd0), 32'd2);
    check("t3_fifo_empty", 32'(cmd_fifo.size()), 32'd0);

    // Group spacing with a short period.
    iPeriod = 16'd3;
    wr_t.delete();
    push_frame(8'h01, 2, -1);
    cmd_fifo.push_back(32'h1010_0002);
    wait_eof("t3b", 200);
    check("t3b_words", 32'(wr_t.size()), 32'd4);
    if (wr_t.size() == 4) check("t3b_gap", 32'(wr_t[2] - wr_t[1]), 32'd6);
    iPeriod = '0;

    // Zero mask and unknown opcode are consumed silently.
    w0 = words;
    rd0 = rd_cnt;
    b0 = busy_cnt;
    cmd_fifo.push_back(32'h1000_0010);
    cmd_fifo.push_back(32'h7030_0002);
    repeat (20) @(posedge iClk);
    check("t4_rd_cnt", 32'(rd_cnt - rd0), 32'd2);
    check("t4_no_wr", 32'(words - w0), 32'd0);
    check("t4_no_busy", 32'(busy_cnt - b0), 32'd0);

    // Zero sample count: header then trailer only.
    w0 = words;
    push_frame(8'h01, 0, -1);
    cmd_fifo.push_back(32'h1010_0000);
    wait_eof("t4z", 100);
    check("t4z_words", 32'(words - w0), 32'd2);

    // Long single-channel capture wraps the address.
    w0 = words;
    push_frame(8'h01, 300, -1);
    cmd_fifo.push_back(32'h1010_012C);
    wait_eof("t5", 3000);
    check("t5_words", 32'(words - w0), 32'd302);

    // Reset in the middle of a frame, then a clean frame.
    w0 = words;
    exp_q.push_back({1'b0, 16'hA003});
    exp_q.push_back({1'b0, 16'h0000});
    cmd_fifo.push_back(32'h1030_0002);
    wait_words("t6", w0 + 2);
    @(posedge iClk);
    #2 iReset_n = 1'b0;
    #1 check_idle_outputs("rst_mid");
    repeat (3) @(posedge iClk);
    #1 iReset_n = 1'b1;
    check("t6_sb_partial", 32'(exp_q.size()), 32'd0);
    check("t6_fifo_empty", 32'(cmd_fifo.size()), 32'd0);
    push_frame(8'h03, 2, -1);
    cmd_fifo.push_back(32'h1030_0002);
    wait_eof("t6", 200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
